// File: rtl/writeback_stage.sv
// Writeback stage: selects the register-file write source and waits in WAIT_MEM
// for load data, which it formats. A load whose data never arrives times out.
module writeback_stage #(
   parameter int unsigned LOAD_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ex_valid,
   input  logic [4:0]  ex_rd,
   input  logic        ex_reg_wr,
   input  logic [1:0]  ex_wb_sel,
   input  logic [31:0] ex_alu_res,
   input  logic [31:0] ex_pc,
   input  logic [2:0]  ex_load_type,
   input  logic [31:0] csr_rdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_rvalid,
   output logic        reg_wr,
   output logic [4:0]  waddr,
   output logic [31:0] wdata,
   output logic        stall,
   output logic [4:0]  pend_rd,
   output logic        load_err
);

   localparam logic [3:0] TIMEOUT_CNT = LOAD_TIMEOUT[3:0];

   typedef enum logic {IDLE, WAIT_MEM} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  cnt_inc;
   logic [4:0]  rd_q, rd_d;
   logic [2:0]  ltype_q, ltype_d;
   logic [1:0]  addr_q, addr_d;
   logic        reg_wr_d;
   logic [4:0]  waddr_d;
   logic [31:0] wdata_d;
   logic        load_err_d;

   // Byte/half lane extraction and extension of the raw memory word.
   function automatic logic [31:0] fmt_load(input logic [2:0]  lt,
                                            input logic [1:0]  a,
                                            input logic [31:0] d);
      logic [31:0] sh;
      logic [7:0]  b;
      logic [15:0] h;
      sh = d >> {a, 3'b000};
      b  = sh[7:0];
      h  = a[1] ? d[31:16] : d[15:0];
      case (lt)
         3'b000:  fmt_load = {{24{b[7]}}, b};
         3'b001:  fmt_load = {{16{h[15]}}, h};
         3'b100:  fmt_load = {24'd0, b};
         3'b101:  fmt_load = {16'd0, h};
         default: fmt_load = d;
      endcase
   endfunction

   assign cnt_inc = cnt_q + 4'd1;
   assign stall   = (state_q == WAIT_MEM);
   assign pend_rd = stall ? rd_q : 5'd0;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rd_d       = rd_q;
      ltype_d    = ltype_q;
      addr_d     = addr_q;
      reg_wr_d   = 1'b0;
      waddr_d    = waddr;
      wdata_d    = wdata;
      load_err_d = load_err;
      case (state_q)
         IDLE: begin
            if (ex_valid) begin
               if (ex_wb_sel == 2'd1) begin
                  rd_d    = ex_rd;
                  ltype_d = ex_load_type;
                  addr_d  = ex_alu_res[1:0];
                  cnt_d   = 4'd0;
                  state_d = WAIT_MEM;
               end else begin
                  reg_wr_d = ex_reg_wr && (ex_rd != 5'd0);
                  waddr_d  = ex_rd;
                  case (ex_wb_sel)
                     2'd2:    wdata_d = ex_pc + 32'd4;
                     2'd3:    wdata_d = csr_rdata;
                     default: wdata_d = ex_alu_res;
                  endcase
               end
            end
         end
         WAIT_MEM: begin
            // Data arriving on the timeout cycle still counts as a good load.
            if (dmem_rvalid) begin
               reg_wr_d = (rd_q != 5'd0);
               waddr_d  = rd_q;
               wdata_d  = fmt_load(ltype_q, addr_q, dmem_rdata);
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == TIMEOUT_CNT) begin
                  reg_wr_d   = (rd_q != 5'd0);
                  waddr_d    = rd_q;
                  wdata_d    = 32'd0;
                  load_err_d = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         rd_q     <= 5'd0;
         ltype_q  <= 3'd0;
         addr_q   <= 2'd0;
         reg_wr   <= 1'b0;
         waddr    <= 5'd0;
         wdata    <= 32'd0;
         load_err <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
         ltype_q  <= ltype_d;
         addr_q   <= addr_d;
         reg_wr   <= reg_wr_d;
         waddr    <= waddr_d;
         wdata    <= wdata_d;
         load_err <= load_err_d;
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: vector table through a scoreboard,
// plus hand sequences for load bubble, timeout and reset during a load.
module tb_writeback_stage;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic [4:0]  ex_rd;
   logic        ex_reg_wr;
   logic [1:0]  ex_wb_sel;
   logic [31:0] ex_alu_res;
   logic [31:0] ex_pc;
   logic [2:0]  ex_load_type;
   logic [31:0] csr_rdata;
   logic [31:0] dmem_rdata;
   logic        dmem_rvalid;
   logic        reg_wr;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        stall;
   logic [4:0]  pend_rd;
   logic        load_err;

   always #5 clk = ~clk;

   writeback_stage #(.LOAD_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
      .ex_wb_sel(ex_wb_sel), .ex_alu_res(ex_alu_res), .ex_pc(ex_pc),
      .ex_load_type(ex_load_type), .csr_rdata(csr_rdata), .dmem_rdata(dmem_rdata),
      .dmem_rvalid(dmem_rvalid), .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata),
      .stall(stall), .pend_rd(pend_rd), .load_err(load_err)
   );

   typedef struct {
      logic [1:0]  sel;
      logic [4:0]  rd;
      logic        wr_en;
      logic [31:0] alu;
      logic [31:0] pc;
      logic [31:0] csr;
      logic [2:0]  lt;
      int          delay;
      logic [31:0] rdata;
      logic        exp_wr;
      logic [31:0] exp_wdata;
   } vec_t;

   localparam int NV = 17;
   vec_t        vecs[NV];
   logic [37:0] exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic        exp_err  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic junk_ex();
      ex_rd        = 5'($urandom_range(0, 31));
      ex_reg_wr    = 1'($urandom_range(0, 1));
      ex_wb_sel    = 2'($urandom_range(0, 3));
      ex_alu_res   = $urandom;
      ex_pc        = $urandom;
      ex_load_type = 3'($urandom_range(0, 7));
      csr_rdata    = $urandom;
   endtask

   task automatic drive_ex(input logic [1:0] sel, input logic [4:0] rd, input logic wr_en,
                           input logic [31:0] alu, input logic [31:0] pc,
                           input logic [31:0] csr, input logic [2:0] lt);
      ex_valid     = 1'b1;
      ex_wb_sel    = sel;
      ex_rd        = rd;
      ex_reg_wr    = wr_en;
      ex_alu_res   = alu;
      ex_pc        = pc;
      ex_csr_set(csr);
      ex_load_type = lt;
   endtask

   task automatic ex_csr_set(input logic [31:0] csr);
      csr_rdata = csr;
   endtask

   task automatic check_out(input string tag);
      logic [37:0] e;
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_reg_wr"}, 32'(reg_wr), 32'(e[37]));
         chk({tag, "_waddr"},  32'(waddr),  32'(e[36:32]));
         chk({tag, "_wdata"},  wdata,       e[31:0]);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      int    stall_cycles;
      tag = $sformatf("v%0d", idx);
      drive_ex(v.sel, v.rd, v.wr_en, v.alu, v.pc, v.csr, v.lt);
      dmem_rvalid = (v.sel != 2'd1) ? 1'($urandom_range(0, 1)) : 1'b0;
      dmem_rdata  = $urandom;
      exp_q.push_back({v.exp_wr, v.rd, v.exp_wdata});
      cycle();
      ex_valid    = 1'b0;
      dmem_rvalid = 1'b0;
      junk_ex();
      if (v.sel == 2'd1) begin
         stall_cycles = 0;
         for (int i = 0; i < v.delay; i++) begin
            chk({tag, "_pend_rd"}, 32'(pend_rd), 32'(v.rd));
            chk({tag, "_wait_reg_wr"}, 32'(reg_wr), 32'd0);
            stall_cycles += int'(stall);
            cycle();
         end
         chk({tag, "_pend_rd"}, 32'(pend_rd), 32'(v.rd));
         stall_cycles += int'(stall);
         dmem_rvalid = 1'b1;
         dmem_rdata  = v.rdata;
         cycle();
         dmem_rvalid = 1'b0;
         chk({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(v.delay + 1));
         chk({tag, "_pend_rd_done"}, 32'(pend_rd), 32'd0);
      end
      chk({tag, "_stall"}, 32'(stall), 32'd0);
      check_out(tag);
      chk({tag, "_load_err"}, 32'(load_err), 32'(exp_err));
      dmem_rvalid = 1'($urandom_range(0, 1));
      cycle();
      dmem_rvalid = 1'b0;
      chk({tag, "_reg_wr_drop"}, 32'(reg_wr), 32'd0);
      chk({tag, "_waddr_hold"}, 32'(waddr), 32'(v.rd));
      chk({tag, "_wdata_hold"}, wdata, v.exp_wdata);
   endtask

   initial begin
      vecs[0]  = '{2'd0, 5'd5,  1'b1, 32'h1234_5678, 32'h100,       32'h0, 3'b000, 0, 32'h0, 1'b1, 32'h1234_5678};
      vecs[1]  = '{2'd2, 5'd0,  1'b1, 32'h0,         32'hFFFF_FFFC, 32'h0, 3'b000, 0, 32'h0, 1'b0, 32'h0};
      vecs[2]  = '{2'd2, 5'd1,  1'b1, 32'h77,        32'h0000_1000, 32'h0, 3'b000, 0, 32'h0, 1'b1, 32'h0000_1004};
      vecs[3]  = '{2'd3, 5'd31, 1'b1, 32'h5,         32'h0,  32'hDEAD_BEEF, 3'b000, 0, 32'h0, 1'b1, 32'hDEAD_BEEF};
      vecs[4]  = '{2'd0, 5'd9,  1'b0, 32'h55,        32'h0,         32'h0, 3'b000, 0, 32'h0, 1'b0, 32'h55};
      vecs[5]  = '{2'd1, 5'd10, 1'b1, 32'h1003, 32'h0, 32'h0, 3'b000, 2,  32'h80FF_0000, 1'b1, 32'hFFFF_FF80};
      vecs[6]  = '{2'd1, 5'd11, 1'b1, 32'h2002, 32'h0, 32'h0, 3'b101, 0,  32'h8001_1234, 1'b1, 32'h0000_8001};
      vecs[7]  = '{2'd1, 5'd12, 1'b1, 32'h2002, 32'h0, 32'h0, 3'b001, 1,  32'h8001_1234, 1'b1, 32'hFFFF_8001};
      vecs[8]  = '{2'd1, 5'd13, 1'b1, 32'h1,    32'h0, 32'h0, 3'b100, 0,  32'h1234_8756, 1'b1, 32'h0000_0087};
      vecs[9]  = '{2'd1, 5'd15, 1'b1, 32'h0,    32'h0, 32'h0, 3'b000, 1,  32'h0000_007F, 1'b1, 32'h0000_007F};
      vecs[10] = '{2'd1, 5'd14, 1'b1, 32'h40,   32'h0, 32'h0, 3'b010, 3,  32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
      vecs[11] = '{2'd1, 5'd16, 1'b1, 32'h41,   32'h0, 32'h0, 3'b011, 0,  32'h0102_0304, 1'b1, 32'h0102_0304};
      vecs[12] = '{2'd1, 5'd17, 1'b1, 32'h0,    32'h0, 32'h0, 3'b001, 0,  32'h0000_8000, 1'b1, 32'hFFFF_8000};
      vecs[13] = '{2'd1, 5'd0,  1'b1, 32'h0,    32'h0, 32'h0, 3'b010, 0,  32'h1357_2468, 1'b0, 32'h1357_2468};
      vecs[14] = '{2'd1, 5'd18, 1'b1, 32'h4,    32'h0, 32'h0, 3'b010, TO - 1, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D};
      vecs[15] = '{2'd1, 5'd19, 1'b1, 32'h3,    32'h0, 32'h0, 3'b100, 0,  32'hF000_0000, 1'b1, 32'h0000_00F0};
      vecs[16] = '{2'd1, 5'd20, 1'b1, 32'h0,    32'h0, 32'h0, 3'b101, 2,  32'h1234_F00F, 1'b1, 32'h0000_F00F};

      // Reset with a live instruction on the inputs: reset must win.
      rst = 1'b1;
      drive_ex(2'd0, 5'd5, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0, 3'b000);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'hFFFF_FFFF;
      cycle();
      cycle();
      rst         = 1'b0;
      ex_valid    = 1'b0;
      dmem_rvalid = 1'b0;
      chk("rst_reg_wr",   32'(reg_wr),   32'd0);
      chk("rst_waddr",    32'(waddr),    32'd0);
      chk("rst_wdata",    wdata,         32'd0);
      chk("rst_stall",    32'(stall),    32'd0);
      chk("rst_pend_rd",  32'(pend_rd),  32'd0);
      chk("rst_load_err", 32'(load_err), 32'd0);

      for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

      // Upstream holds an ALU op during the load: ignored until the bubble passes.
      drive_ex(2'd1, 5'd3, 1'b1, 32'h0, 32'h0, 32'h0, 3'b010);
      cycle();
      drive_ex(2'd0, 5'd21, 1'b1, 32'hA5A5_A5A5, 32'h0, 32'h0, 3'b000);
      chk("bub_stall", 32'(stall), 32'd1);
      cycle();
      chk("bub_wait_reg_wr", 32'(reg_wr), 32'd0);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h1111_2222;
      exp_q.push_back({1'b1, 5'd3, 32'h1111_2222});
      cycle();
      dmem_rvalid = 1'b0;
      chk("bub_stall_done", 32'(stall), 32'd0);
      check_out("bub_load");
      exp_q.push_back({1'b1, 5'd21, 32'hA5A5_A5A5});
      cycle();
      ex_valid = 1'b0;
      check_out("bub_alu");
      cycle();
      chk("bub_reg_wr_drop", 32'(reg_wr), 32'd0);

      // Load that never gets data.
      drive_ex(2'd1, 5'd7, 1'b1, 32'h0, 32'h0, 32'h0, 3'b010);
      cycle();
      ex_valid = 1'b0;
      for (int i = 0; i < TO; i++) begin
         chk($sformatf("to_stall_%0d", i), 32'(stall), 32'd1);
         chk($sformatf("to_err_%0d", i), 32'(load_err), 32'd0);
         cycle();
      end
      exp_q.push_back({1'b1, 5'd7, 32'h0});
      exp_err = 1'b1;
      check_out("timeout");
      chk("to_stall_done", 32'(stall), 32'd0);
      chk("to_load_err", 32'(load_err), 32'd1);
      run_vec(vecs[0], 100);
      chk("to_err_sticky", 32'(load_err), 32'd1);

      // Reset in WAIT_MEM abandons the load; late data is ignored.
      drive_ex(2'd1, 5'd8, 1'b1, 32'h0, 32'h0, 32'h0, 3'b010);
      cycle();
      ex_valid = 1'b0;
      chk("rw_stall", 32'(stall), 32'd1);
      chk("rw_pend_rd", 32'(pend_rd), 32'd8);
      cycle();
      rst = 1'b1;
      cycle();
      rst     = 1'b0;
      exp_err = 1'b0;
      chk("rw_stall_off", 32'(stall), 32'd0);
      chk("rw_reg_wr", 32'(reg_wr), 32'd0);
      chk("rw_load_err", 32'(load_err), 32'd0);
      chk("rw_pend_rd_off", 32'(pend_rd), 32'd0);
      dmem_rvalid = 1'b1;
      dmem_rdata  = 32'h7777_7777;
      cycle();
      dmem_rvalid = 1'b0;
      chk("rw_late_reg_wr", 32'(reg_wr), 32'd0);
      chk("rw_late_stall", 32'(stall), 32'd0);
      chk("rw_late_waddr", 32'(waddr), 32'd0);
      chk("rw_late_wdata", wdata, 32'd0);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter LOAD_TIMEOUT, default 15: WAIT_MEM cycles without dmem_rvalid before the load is abandoned; legal range 1-15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ex_valid  input  1  execute stage presents an instruction this cycle.
REQ-005 ex_rd  input  5  destination register.
REQ-006 ex_reg_wr  input  1  instruction writes rd.
REQ-007 ex_wb_sel  input  2  writeback source: 0 ALU, 1 memory load, 2 PC+4, 3 CSR.
REQ-008 ex_alu_res  input  32  ALU result; load address when ex_wb_sel=1.
REQ-009 ex_pc  input  32  instruction PC.
REQ-010 ex_load_type  input  3  funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-011 csr_rdata  input  32  CSR read data, valid in the ex_valid cycle.
REQ-012 dmem_rdata  input  32  data-memory read word.
REQ-013 dmem_rvalid  input  1  dmem_rdata valid this cycle.
REQ-014 reg_wr  output  1  register-file write enable, registered.
REQ-015 waddr  output  5  register-file write address, registered.
REQ-016 wdata  output  32  register-file write data, registered.
REQ-017 stall  output  1  high while state is WAIT_MEM; upstream holds its outputs.
REQ-018 pend_rd  output  5  rd of the outstanding load, valid while stall=1, else 0.
REQ-019 load_err  output  1  sticky flag: a load timed out.

Function
REQ-020 The block SHALL contain a two-state FSM with states IDLE and WAIT_MEM.
REQ-021 Capture: in IDLE with ex_valid=1 on a rising edge, the block SHALL accept the instruction; ex_* inputs SHALL be ignored in WAIT_MEM and when ex_valid=0.
REQ-022 Non-load capture: next cycle reg_wr=ex_reg_wr AND (ex_rd!=0), waddr=ex_rd, wdata = ex_alu_res (sel 0), ex_pc+4 mod 2^32 (sel 2), or csr_rdata (sel 3); latency 1 cycle.
REQ-023 Load capture (sel 1): the block SHALL set reg_wr=0, latch rd, load_type and address bits [1:0], clear the timeout counter, and enter WAIT_MEM.
REQ-024 In WAIT_MEM with dmem_rvalid=1: next cycle reg_wr=1 if latched rd!=0, waddr=rd, wdata=formatted load, state IDLE.
REQ-025 Formatting: LB/LBU select byte dmem_rdata[8*a+7:8*a] (a=addr[1:0]); LH/LHU select half at addr[1]*16; LB/LH sign-extend, LBU/LHU zero-extend; LW and any undefined funct3 pass the full word.
REQ-026 In WAIT_MEM with dmem_rvalid=0 the counter SHALL increment; the cycle it equals LOAD_TIMEOUT the block SHALL write wdata=0 to latched rd (reg_wr=1 if rd!=0), set load_err=1, and return to IDLE.
REQ-027 rvalid and timeout in the same cycle: rvalid wins; data written, load_err unchanged.
REQ-028 reg_wr SHALL be high for exactly one cycle per accepted write; with no accept/completion, reg_wr=0 next cycle; waddr/wdata hold last value.
REQ-029 A write to x0 SHALL never assert reg_wr.
REQ-030 dmem_rvalid in IDLE SHALL be ignored.
REQ-031 stall SHALL deassert the cycle after load completion; the next instruction is capturable at the following edge (one-bubble minimum load-to-next).

Reset
REQ-032 With rst=1 at a rising edge: state IDLE, reg_wr=0, waddr=0, wdata=0, stall=0, pend_rd=0, load_err=0, counter=0; rst overrides all other inputs.
REQ-033 Reset during WAIT_MEM SHALL abandon the load with no register write; a later dmem_rvalid SHALL be ignored.

Verification
REQ-034 ALU op: ex_valid=1, rd=5, sel=0, alu_res=0x1234_5678 -> next cycle reg_wr=1, waddr=5, wdata=0x1234_5678; following cycle reg_wr=0.
REQ-035 LB at addr 0x...03, dmem_rdata=0x80FF_0000 after 2 wait cycles -> stall high 3 cycles, then wdata=0xFFFF_FF80, waddr=rd, reg_wr=1.
REQ-036 LHU at addr 0x...02, dmem_rdata=0x8001_1234 -> wdata=0x0000_8001; same with LH -> 0xFFFF_8001.
REQ-037 Load, rd=7, no dmem_rvalid for LOAD_TIMEOUT cycles -> wdata=0, waddr=7, reg_wr=1, load_err=1 and stays 1 until rst.
REQ-038 JAL sel=2, pc=0xFFFF_FFFC, rd=0 -> wdata=0x0000_0000, reg_wr=0.
REQ-039 rst asserted in WAIT_MEM, dmem_rvalid pulsed next cycle -> stall=0, reg_wr stays 0, no write.
